// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch sequencer: 2-bit controller state encoding.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10,
    ST_LAP  = 2'b11
  } sw_state_e;

  // Bit 0 of the encoding marks the two counting states (RUN, LAP).
  function automatic logic is_counting(sw_state_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Free-running divider that pulses tick once every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count;

  // Holding the count while en is low lets a paused user keep the tick phase.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear sequencer driving the cascaded BCD stopwatch chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int DIV_W      = 20,
  parameter int SAT_AT_MAX = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic       chain_at_max,
  output logic       cnt_inc,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state,
  output logic       overflow
);

  // Buttons are single-cycle event pulses with no backpressure: every high
  // cycle is consumed on the next edge, and start_stop wins over lap_reset.

  localparam logic SAT = (SAT_AT_MAX != 0);

  sw_state_e state_q;
  sw_state_e state_d;
  logic      tick;
  logic      max_hit;

  tick_gen #(
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (is_counting(state_q)),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  assign max_hit = tick && chain_at_max;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_stop) state_d = ST_RUN;
      ST_RUN: begin
        if (start_stop)     state_d = ST_STOP;
        else if (lap_reset) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (start_stop)     state_d = ST_STOP;
        else if (lap_reset) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (start_stop)     state_d = ST_RUN;
        else if (lap_reset) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Saturating at the chain maximum beats any button pressed that cycle.
    if (SAT && max_hit) state_d = ST_STOP;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset)                   overflow <= 1'b0;
    else if (state_d == ST_IDLE) overflow <= 1'b0;
    else if (max_hit)            overflow <= 1'b1;
  end

  // A tick landing in a reset cycle must not disturb the chain being cleared.
  assign cnt_inc   = tick && !(SAT && chain_at_max) && !reset;
  assign cnt_clr   = (state_q == ST_IDLE);
  assign disp_hold = (state_q == ST_LAP);
  assign running   = is_counting(state_q);
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: saturating and wrapping instances against a reference model.
module tb_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int MAXV = 359999;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STOP = 2'b10, S_LAP = 2'b11;
  localparam logic [6:0] RESET_OUTS = 7'b0100000;

  logic       clk = 1'b0;
  logic       reset, start_stop, lap_reset;
  logic       at_max [2];
  logic       inc [2], clr [2], hold [2], runo [2], ovf [2];
  logic [1:0] st [2];

  int errors = 0;
  int checks = 0;

  // Environment: the BCD chain and display latch, driven by the DUT outputs
  int dig [2][6];
  int lim [6] = '{10, 10, 10, 6, 10, 6};
  int e_disp [2];

  // Reference model, in plain time units
  logic [1:0] m_state [2];
  int         m_run [2];
  bit         m_ovf [2];
  int         m_chain [2];
  int         m_disp [2];

  logic [6:0] obs_v [2];
  logic [6:0] exp_v [2];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3), .SAT_AT_MAX(1)) dut_sat (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
    .chain_at_max(at_max[0]), .cnt_inc(inc[0]), .cnt_clr(clr[0]),
    .disp_hold(hold[0]), .running(runo[0]), .state(st[0]), .overflow(ovf[0])
  );

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3), .SAT_AT_MAX(0)) dut_wrap (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
    .chain_at_max(at_max[1]), .cnt_inc(inc[1]), .cnt_clr(clr[1]),
    .disp_hold(hold[1]), .running(runo[1]), .state(st[1]), .overflow(ovf[1])
  );

  function automatic int bcd_val(input int k);
    return dig[k][0] + 10 * dig[k][1] + 100 * dig[k][2] + 1000 * dig[k][3]
         + 6000 * dig[k][4] + 60000 * dig[k][5];
  endfunction

  task automatic bcd_inc(input int k);
    bit carry;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        dig[k][i]++;
        if (dig[k][i] == lim[i]) dig[k][i] = 0;
        else                     carry = 1'b0;
      end
    end
  endtask

  task automatic preload(input int k, input int v);
    int r;
    r = v;
    dig[k][5] = r / 60000; r = r % 60000;
    dig[k][4] = r / 6000;  r = r % 6000;
    dig[k][3] = r / 1000;  r = r % 1000;
    dig[k][2] = r / 100;   r = r % 100;
    dig[k][1] = r / 10;
    dig[k][0] = r % 10;
    m_chain[k] = v;
  endtask

  // One clock cycle: drive inputs, form expectations, sample at negedge, advance.
  task automatic step(input bit ss, input bit lr, input bit rst);
    bit         cnt [2], tick [2], hit [2], e_inc [2], e_clr [2], e_hold [2];
    logic [1:0] nx;
    reset = rst; start_stop = ss; lap_reset = lr;
    for (int k = 0; k < 2; k++) begin
      at_max[k] = (bcd_val(k) == MAXV);
      cnt[k]    = (m_state[k] == S_RUN) || (m_state[k] == S_LAP);
      tick[k]   = cnt[k] && (m_run[k] % TD == TD - 1);
      hit[k]    = tick[k] && (m_chain[k] == MAXV);
      e_inc[k]  = tick[k] && !(k == 0 && hit[k]) && !rst;
      e_clr[k]  = (m_state[k] == S_IDLE);
      e_hold[k] = (m_state[k] == S_LAP);
      exp_v[k]  = {e_inc[k], e_clr[k], e_hold[k], cnt[k], m_state[k], m_ovf[k]};
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      obs_v[k] = {inc[k], clr[k], hold[k], runo[k], st[k], ovf[k]};
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (obs_v[k][4] !== 1'b1) e_disp[k] = bcd_val(k);
      if (obs_v[k][5] === 1'b1)      for (int i = 0; i < 6; i++) dig[k][i] = 0;
      else if (obs_v[k][6] === 1'b1) bcd_inc(k);
      if (!e_hold[k]) m_disp[k] = m_chain[k];
      if (e_clr[k])      m_chain[k] = 0;
      else if (e_inc[k]) m_chain[k] = (m_chain[k] + 1) % (MAXV + 1);
      if (rst) begin
        m_state[k] = S_IDLE; m_run[k] = 0; m_ovf[k] = 1'b0;
      end else begin
        nx = m_state[k];
        case (m_state[k])
          S_IDLE: if (ss) nx = S_RUN;
          S_RUN:  if (ss) nx = S_STOP; else if (lr) nx = S_LAP;
          S_LAP:  if (ss) nx = S_STOP; else if (lr) nx = S_RUN;
          default: if (ss) nx = S_RUN; else if (lr) nx = S_IDLE;
        endcase
        if (hit[k] && k == 0) nx = S_STOP;
        if (hit[k]) m_ovf[k] = 1'b1;
        if (cnt[k]) m_run[k]++;
        if (nx == S_IDLE) begin
          m_ovf[k] = 1'b0; m_run[k] = 0;
        end
        m_state[k] = nx;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      step(0, 0, c == 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== RESET_OUTS) begin
          errors++;
          $display("FAIL reset_outs dut%0d: got %b want %b", k, obs_v[k], RESET_OUTS);
        end
      end
    end
  endtask

  task automatic test_first_tick();
    int first_inc;
    first_inc = -1;
    step(1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL first_tick dut%0d cyc%0d: got %b want %b", k, c, obs_v[k], exp_v[k]);
        end
      end
      if (obs_v[0][6] === 1'b1 && first_inc < 0) first_inc = c;
    end
    checks++;
    if (first_inc != TD) begin
      errors++;
      $display("FAIL first_inc_latency: got %0d want %0d", first_inc, TD);
    end
    checks++;
    if (bcd_val(0) != 5) begin
      errors++;
      $display("FAIL chain_after_5_ticks: got %0d want 5", bcd_val(0));
    end
  endtask

  task automatic test_stop_resume();
    int stopped_incs, wait_inc;
    for (int c = 0; c < 22; c++) step(0, 0, 0);
    checks++;
    if (bcd_val(0) != 10) begin
      errors++;
      $display("FAIL chain_after_10_ticks: got %0d want 10", bcd_val(0));
    end
    step(1, 0, 0);
    stopped_incs = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0);
      if (obs_v[0][6] !== 1'b0 || obs_v[1][6] !== 1'b0) stopped_incs++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL stopped dut%0d cyc%0d: got %b want %b", k, c, obs_v[k], exp_v[k]);
        end
      end
    end
    checks++;
    if (stopped_incs != 0) begin
      errors++;
      $display("FAIL inc_while_stopped: got %0d want 0", stopped_incs);
    end
    step(1, 0, 0);
    wait_inc = -1;
    for (int c = 1; c <= TD && wait_inc < 0; c++) begin
      step(0, 0, 0);
      if (obs_v[0][6] === 1'b1) wait_inc = c;
    end
    checks++;
    if (wait_inc != 1) begin
      errors++;
      $display("FAIL resume_phase: first inc after %0d cycles, want 1", wait_inc);
    end
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v[k][5] !== 1'b1 || st[k] !== S_IDLE || bcd_val(k) != 0) begin
        errors++;
        $display("FAIL clear_from_stop dut%0d: clr=%b state=%b chain=%0d want 1/00/0",
                 k, obs_v[k][5], st[k], bcd_val(k));
      end
    end
  endtask

  task automatic test_lap();
    int held, lap_incs;
    step(1, 0, 0);
    for (int c = 0; c < 6; c++) step(0, 0, 0);
    step(0, 1, 0);
    held = e_disp[0];
    lap_incs = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, 0, 0);
      if (obs_v[0][6] === 1'b1) lap_incs++;
      checks++;
      if (obs_v[0] !== exp_v[0] || e_disp[0] != held) begin
        errors++;
        $display("FAIL lap_hold cyc%0d: outs=%b want %b disp=%0d want %0d",
                 c, obs_v[0], exp_v[0], e_disp[0], held);
      end
    end
    checks++;
    if (lap_incs != 3) begin
      errors++;
      $display("FAIL lap_counting: got %0d incs want 3", lap_incs);
    end
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (obs_v[0][4] !== 1'b0 || e_disp[0] != m_disp[0] || e_disp[0] == held) begin
      errors++;
      $display("FAIL lap_release: hold=%b disp=%0d want 0/%0d", obs_v[0][4], e_disp[0], m_disp[0]);
    end
  endtask

  task automatic test_max();
    step(0, 0, 1);
    step(1, 0, 0);
    for (int k = 0; k < 2; k++) preload(k, MAXV);
    for (int c = 0; c < TD; c++) step(0, 0, 0);
    checks++;
    if (obs_v[0][6] !== 1'b0 || obs_v[1][6] !== 1'b1) begin
      errors++;
      $display("FAIL max_inc: sat=%b wrap=%b want 0/1", obs_v[0][6], obs_v[1][6]);
    end
    step(0, 0, 0);
    checks++;
    if (st[0] !== S_STOP || obs_v[0][0] !== 1'b1 || bcd_val(0) != MAXV) begin
      errors++;
      $display("FAIL sat_stop: state=%b ovf=%b chain=%0d want 10/1/%0d",
               st[0], obs_v[0][0], bcd_val(0), MAXV);
    end
    checks++;
    if (st[1] !== S_RUN || obs_v[1][0] !== 1'b1 || bcd_val(1) > 1) begin
      errors++;
      $display("FAIL wrap_run: state=%b ovf=%b chain=%0d want 01/1/0", st[1], obs_v[1][0], bcd_val(1));
    end
    step(0, 1, 0);
    step(0, 0, 0);
    checks++;
    if (st[0] !== S_IDLE || obs_v[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: state=%b ovf=%b want 00/0", st[0], obs_v[0][0]);
    end
    checks++;
    if (st[1] !== S_LAP || obs_v[1][0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ovf_sticky: state=%b ovf=%b want 11/1", st[1], obs_v[1][0]);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    step(0, 0, 1);
    step(1, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (st[k] !== S_STOP) begin
        errors++;
        $display("FAIL both_pulses dut%0d: state=%b want 10", k, st[k]);
      end
    end
    step(1, 0, 0);
    guard = 0;
    while (m_run[0] % TD != TD - 1 && guard < 2 * TD) begin
      step(0, 0, 0);
      guard++;
    end
    step(0, 0, 1);
    checks++;
    if (obs_v[0][6] !== 1'b0 || obs_v[1][6] !== 1'b0 || guard >= 2 * TD) begin
      errors++;
      $display("FAIL reset_cycle_inc: got %b%b want 00 (guard %0d)", obs_v[0][6], obs_v[1][6], guard);
    end
    step(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v[k] !== RESET_OUTS) begin
        errors++;
        $display("FAIL mid_run_reset dut%0d: got %b want %b", k, obs_v[k], RESET_OUTS);
      end
    end
  endtask

  task automatic test_random();
    bit ss, lr, rst;
    for (int c = 0; c < 800; c++) begin
      ss  = ($urandom_range(0, 19) == 0);
      lr  = ($urandom_range(0, 14) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0)
        for (int k = 0; k < 2; k++) preload(k, MAXV - $urandom_range(0, 2));
      step(ss, lr, rst);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k] || bcd_val(k) != m_chain[k] || e_disp[k] != m_disp[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: outs=%b want %b chain=%0d want %0d disp=%0d want %0d",
                   k, c, obs_v[k], exp_v[k], bcd_val(k), m_chain[k], e_disp[k], m_disp[k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap_reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      at_max[k] = 1'b0; m_state[k] = S_IDLE; m_run[k] = 0; m_ovf[k] = 1'b0;
      m_chain[k] = 0; m_disp[k] = 0; e_disp[k] = 0;
      for (int i = 0; i < 6; i++) dig[k][i] = 0;
    end
    test_reset();
    test_first_tick();
    test_stop_resume();
    test_lap();
    test_max();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
